// File: rtl/dump_pkg.sv
// Shared constants, state encoding and byte-lane helper for the memory dumper.
package dump_pkg;

    // Word address width of program RAM; byte pointer adds the two lane bits.
    localparam int unsigned RAM_ADDR_BITS = 14;
    localparam int unsigned PTR_BITS      = RAM_ADDR_BITS + 2;

    typedef enum logic [2:0] {
        StIdle         = 3'd0,
        StSendSize     = 3'd1,
        StRead         = 3'd2,
        StWaitData     = 3'd3,
        StSendData     = 3'd4,
        StSendChecksum = 3'd5,
        StDone         = 3'd6
    } dump_state_e;

    // Big-endian lane select: lane 0 is the most significant byte of the word.
    function automatic logic [7:0] select_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        b = 8'h00;
        unique case (lane)
            2'd0: b = word[31:24];
            2'd1: b = word[23:16];
            2'd2: b = word[15:8];
            2'd3: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dump_if.sv
// RAM read port and byte-stream transmit handshake between the dumper and its peers.
interface dump_if;
    import dump_pkg::*;

    logic [RAM_ADDR_BITS-1:0] ram_addr;
    logic [3:0]               ram_byteen;
    logic                     ram_rden;
    logic                     ram_wren;
    logic [31:0]              ram_wrdata;
    logic [31:0]              ram_rddata;
    logic                     tx_valid;
    logic [7:0]               tx_data;
    logic                     tx_ready;

    modport master (
        output ram_addr, ram_byteen, ram_rden, ram_wren, ram_wrdata,
        input  ram_rddata,
        output tx_valid, tx_data,
        input  tx_ready
    );

    modport slave (
        input  ram_addr, ram_byteen, ram_rden, ram_wren, ram_wrdata,
        output ram_rddata,
        input  tx_valid, tx_data,
        output tx_ready
    );

endinterface

// File: rtl/dump.sv
// Streams a byte range of program RAM out as: 3-byte big-endian length, payload, XOR checksum.
module dump
    import dump_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [PTR_BITS-1:0] base,
    input  logic [23:0]         length,
    output logic                busy,
    output logic                done,
    output logic [5:0]          leds,
    dump_if.master              bus
);

    dump_state_e         state;
    logic [PTR_BITS-1:0] ptr;
    logic [23:0]         remaining;
    logic [1:0]          size_idx;
    logic [7:0]          checksum;

    // Address and lane enable come straight from the pointer register; the word is
    // re-read for every byte, so no separate address latch is needed.
    assign bus.ram_addr   = ptr[PTR_BITS-1:2];
    assign bus.ram_byteen = 4'b1000 >> ptr[1:0];
    assign bus.ram_wren   = 1'b0;
    assign bus.ram_wrdata = 32'h0;
    assign leds           = {checksum[2:0], state};

    // Transfer sequencer with registered handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= StIdle;
            ptr          <= '0;
            remaining    <= 24'h0;
            size_idx     <= 2'd0;
            checksum     <= 8'h00;
            busy         <= 1'b0;
            done         <= 1'b0;
            bus.tx_valid <= 1'b0;
            bus.tx_data  <= 8'h00;
            bus.ram_rden <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        ptr          <= base;
                        remaining    <= length;
                        checksum     <= 8'h00;
                        size_idx     <= 2'd0;
                        busy         <= 1'b1;
                        bus.tx_valid <= 1'b1;
                        bus.tx_data  <= length[23:16];
                        state        <= StSendSize;
                    end
                end
                // remaining is untouched here, so it still holds the length for the header.
                StSendSize: begin
                    if (bus.tx_ready) begin
                        if (size_idx == 2'd2) begin
                            size_idx <= 2'd0;
                            if (remaining == 24'h0) begin
                                bus.tx_data <= checksum;
                                state       <= StSendChecksum;
                            end else begin
                                bus.tx_valid <= 1'b0;
                                bus.ram_rden <= 1'b1;
                                state        <= StRead;
                            end
                        end else begin
                            size_idx    <= size_idx + 2'd1;
                            bus.tx_data <= (size_idx == 2'd0) ? remaining[15:8] : remaining[7:0];
                        end
                    end
                end
                StRead: begin
                    bus.ram_rden <= 1'b0;
                    state        <= StWaitData;
                end
                StWaitData: begin
                    bus.tx_data  <= select_byte(bus.ram_rddata, ptr[1:0]);
                    bus.tx_valid <= 1'b1;
                    state        <= StSendData;
                end
                StSendData: begin
                    if (bus.tx_ready) begin
                        checksum  <= checksum ^ bus.tx_data;
                        ptr       <= ptr + PTR_BITS'(1);
                        remaining <= remaining - 24'd1;
                        if (remaining == 24'd1) begin
                            bus.tx_data <= checksum ^ bus.tx_data;
                            state       <= StSendChecksum;
                        end else begin
                            bus.tx_valid <= 1'b0;
                            bus.ram_rden <= 1'b1;
                            state        <= StRead;
                        end
                    end
                end
                StSendChecksum: begin
                    if (bus.tx_ready) begin
                        bus.tx_valid <= 1'b0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        state        <= StDone;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
